sum_accum_ser: RTL and testbench

SUM_ACCUM_SER -- requirements
Module: sum_accum_ser

---
 rtl/sum_accum_ser.sv | 98 +++++++++
 tb/tb_sum_accum_ser.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum_ser.sv
// Block accumulator: sums N_SAMPLES unsigned bytes into a saturating 16-bit total
// and emits it as two bytes, low first, over a valid/ready output.
// Ports:
//   clk, rst (sync, active-high)
//   in_data/in_valid/in_ready : sample input handshake
//   flush                     : close a partial block early
//   out_data/out_valid/out_ready/out_last : serialized result
//   sat                       : current block's accumulator saturated
module sum_accum_ser #(
  parameter int N_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       sat
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    OUT_LO = 2'd1,
    OUT_HI = 2'd2
  } state_e;

  localparam logic [10:0] LAST = 11'(N_SAMPLES - 1);

  state_e      state_q;
  logic [15:0] acc_q, acc_d;
  logic [10:0] cnt_q, cnt_d;
  logic        sat_q, sat_d;
  logic [16:0] sum;
  logic        in_acc;
  logic        hs;
  logic        done;

  always_comb begin
    in_acc = (state_q == ACCUM);
    hs     = in_valid && in_acc;
    sum    = {1'b0, acc_q} + {9'd0, in_data};
    // bit 16 of the wide sum flags overflow past 16'hFFFF
    acc_d  = sum[16] ? 16'hFFFF : sum[15:0];
    sat_d  = sat_q | sum[16];
    cnt_d  = cnt_q + 11'd1;
    // a flush only closes a block that holds at least one sample
    done   = (hs && (cnt_q == LAST))
          || (flush && in_acc && (hs || (cnt_q != 11'd0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= 16'd0;
      cnt_q   <= 11'd0;
      sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (hs) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end
          if (done) state_q <= OUT_LO;
        end
        OUT_LO: begin
          if (out_ready) state_q <= OUT_HI;
        end
        OUT_HI: begin
          if (out_ready) begin
            acc_q   <= 16'd0;
            cnt_q   <= 11'd0;
            sat_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // outputs decode registered state only, so no input reaches them
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == OUT_LO) || (state_q == OUT_HI);
    out_last  = (state_q == OUT_HI);
    out_data  = 8'd0;
    if (state_q == OUT_LO) out_data = acc_q[7:0];
    if (state_q == OUT_HI) out_data = acc_q[15:8];
    sat       = sat_q;
  end

endmodule

// File: tb/tb_sum_accum_ser.sv
// Testbench for sum_accum_ser: directed vectors plus random traffic
// scored against a block-level arithmetic reference model.
module tb_sum_accum_ser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  logic       r4, v4, l4, s4;
  logic [7:0] d4;
  logic       r3, v3, l3, s3;
  logic [7:0] d3;

  sum_accum_ser #(.N_SAMPLES(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(r4),
    .flush(flush),
    .out_data(d4), .out_valid(v4), .out_ready(out_ready),
    .out_last(l4), .sat(s4)
  );

  sum_accum_ser #(.N_SAMPLES(300)) u_dut300 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(r3),
    .flush(flush),
    .out_data(d3), .out_valid(v3), .out_ready(out_ready),
    .out_last(l3), .sat(s3)
  );

  always #5 clk = ~clk;

  bit         sel;
  logic       o_rdy, o_vld, o_last, o_sat;
  logic [7:0] o_data;

  always_comb begin
    o_rdy  = sel ? r3 : r4;
    o_vld  = sel ? v3 : v4;
    o_last = sel ? l3 : l4;
    o_sat  = sel ? s3 : s4;
    o_data = sel ? d3 : d4;
  end

  typedef struct {
    int data;
    bit last;
    bit sat;
  } obyte_t;

  obyte_t exp_q[$];
  int     got_q[$];
  int     acc_m;
  int     cnt_m;
  int     nsamp;
  int     n_chk;
  int     n_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // one cycle: check outputs, drive inputs, advance the model
  task automatic step(input bit v, input logic [7:0] d,
                      input bit fl, input bit ordy);
    bit     empty;
    int     s;
    bit     st;
    obyte_t b;
    empty = (exp_q.size() == 0);
    check("in_ready", o_rdy, empty);
    check("out_valid", o_vld, !empty);
    if (!empty) begin
      check("out_data", o_data, exp_q[0].data);
      check("out_last", o_last, exp_q[0].last);
      check("sat_out", o_sat, exp_q[0].sat);
    end else begin
      check("idle_data", o_data, 0);
      check("idle_last", o_last, 0);
      check("sat_acc", o_sat, acc_m > 65535);
    end
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    out_ready = ordy;
    if (empty) begin
      if (v) begin
        acc_m += d;
        cnt_m++;
      end
      if ((v && cnt_m == nsamp) || (fl && cnt_m > 0)) begin
        st = acc_m > 65535;
        s  = st ? 65535 : acc_m;
        b.data = s % 256; b.last = 0; b.sat = st;
        exp_q.push_back(b);
        b.data = s / 256; b.last = 1; b.sat = st;
        exp_q.push_back(b);
        acc_m = 0;
        cnt_m = 0;
      end
    end else if (ordy) begin
      got_q.push_back(int'(o_data));
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    acc_m = 0;
    cnt_m = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 0, 1);
  endtask

  task automatic expect_pair(input string tag, input int lo, input int hi);
    check({tag, "_nbytes"}, got_q.size(), 2);
    if (got_q.size() == 2) begin
      check({tag, "_lo"}, got_q[0], lo);
      check({tag, "_hi"}, got_q[1], hi);
    end
    got_q.delete();
  endtask

  initial begin
    int vals[4];
    n_chk = 0;
    n_err = 0;
    sel   = 0;
    nsamp = 4;
    do_reset();

    vals = '{10, 20, 30, 40};
    foreach (vals[i]) step(1, 8'(vals[i]), 0, 1);
    idle(3);
    expect_pair("basic", 'h64, 'h00);

    for (int i = 0; i < 4; i++) step(1, 8'hFF, 0, 1);
    idle(3);
    expect_pair("carry", 'hFC, 'h03);

    step(1, 8'd5, 0, 1);
    step(1, 8'd7, 0, 1);
    step(1, 8'd9, 1, 1);
    idle(3);
    expect_pair("flush", 'h15, 'h00);
    for (int i = 0; i < 4; i++) step(0, 8'd0, 1, 1);
    check("flush_idle_nbytes", got_q.size(), 0);

    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0, 0);
    idle(3);
    expect_pair("bpress", 'h0A, 'h00);

    step(1, 8'd50, 0, 1);
    step(1, 8'd60, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'd1, 0, 1);
    idle(3);
    expect_pair("rst_mid", 'h04, 'h00);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      step($urandom_range(99) < 70, 8'($urandom),
           $urandom_range(99) < 5, $urandom_range(99) < 60);
    end
    idle(4);

    do_reset();
    sel   = 1;
    nsamp = 300;
    idle(1);
    for (int i = 0; i < 300; i++) step(1, 8'hFF, 0, 1);
    idle(3);
    expect_pair("sat", 'hFF, 'hFF);
    check("sat_cleared", o_sat, 0);

    for (int i = 0; i < 900; i++) begin
      step($urandom_range(99) < 80, 8'($urandom_range(255, 128)),
           $urandom_range(999) < 3, $urandom_range(99) < 50);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
